bsg_mem_3r1w_sync_sched: RTL

BSG_MEM_3R1W_SYNC_SCHED -- requirements
Module: bsg_mem_3r1w_sync_sched

---
 rtl/bsg_mem_3r1w_sync_sched.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bsg_mem_3r1w_sync_sched.sv
// bsg_mem_3r1w_sync_sched: round-robin scheduler mapping read requesters onto a 3-read/1-write sync memory
//   clk_i, reset_i                      : clock, synchronous active-high reset
//   req_v_i/req_addr_i/req_yumi_o       : per-requester read request, address and grant
//   rdata_v_o/rdata_o                   : per-requester read data, one cycle after grant
//   w_v_i/w_addr_i/w_data_i/w_ready_o   : write request and acceptance
//   mem_w_*_o, mem_rK_*_o, mem_rK_data_i: memory write port and three read ports
module bsg_mem_3r1w_sync_sched #(
  parameter int width_p = -1,
  parameter int els_p = -1,
  parameter int num_req_p = 4,
  parameter int read_write_same_addr_p = 0,
  parameter int stall_limit_p = 4,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_req_p-1:0]                      req_v_i,
  input  logic [num_req_p-1:0][addr_width_lp-1:0]   req_addr_i,
  output logic [num_req_p-1:0]                      req_yumi_o,
  output logic [num_req_p-1:0]                      rdata_v_o,
  output logic [num_req_p-1:0][width_p-1:0]         rdata_o,
  input  logic                                      w_v_i,
  input  logic [addr_width_lp-1:0]                  w_addr_i,
  input  logic [width_p-1:0]                        w_data_i,
  output logic                                      w_ready_o,
  output logic                                      mem_w_v_o,
  output logic [addr_width_lp-1:0]                  mem_w_addr_o,
  output logic [width_p-1:0]                        mem_w_data_o,
  output logic                                      mem_r0_v_o,
  output logic [addr_width_lp-1:0]                  mem_r0_addr_o,
  input  logic [width_p-1:0]                        mem_r0_data_i,
  output logic                                      mem_r1_v_o,
  output logic [addr_width_lp-1:0]                  mem_r1_addr_o,
  input  logic [width_p-1:0]                        mem_r1_data_i,
  output logic                                      mem_r2_v_o,
  output logic [addr_width_lp-1:0]                  mem_r2_addr_o,
  input  logic [width_p-1:0]                        mem_r2_data_i
);
  localparam int id_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  logic [id_w-1:0] r_rr;
  logic [3:0] r_stall;
  logic [2:0] r_pv;
  logic [id_w-1:0] r_pid [3];
  logic w_prio, w_hz, w_ready, w_any;
  logic [num_req_p-1:0] w_yumi;
  logic [2:0] w_pv;
  logic [id_w-1:0] w_pid [3];
  logic [addr_width_lp-1:0] w_pa [3];
  logic [width_p-1:0] w_rd [3];
  logic [1:0] w_cnt;
  logic [id_w-1:0] w_idx, w_last;
  // once the write has waited stall_limit_p cycles, reads to its address step aside
  assign w_prio = r_stall == 4'(stall_limit_p);
  always_comb begin
    w_yumi = '0;
    w_pv = '0;
    w_cnt = '0;
    w_any = 1'b0;
    w_last = r_rr;
    w_idx = '0;
    for (int k = 0; k < 3; k++) begin
      w_pid[k] = '0;
      w_pa[k] = '0;
    end
    for (int k = 0; k < num_req_p; k++) begin
      w_idx = id_w'((int'(r_rr) + k) % num_req_p);
      if (!reset_i && req_v_i[w_idx] && !(w_prio && req_addr_i[w_idx] == w_addr_i) && w_cnt != 2'd3) begin
        w_yumi[w_idx] = 1'b1;
        w_pv[w_cnt] = 1'b1;
        w_pid[w_cnt] = w_idx;
        w_pa[w_cnt] = req_addr_i[w_idx];
        w_cnt = w_cnt + 2'd1;
        w_last = w_idx;
        w_any = 1'b1;
      end
    end
  end
  always_comb begin
    w_hz = 1'b0;
    for (int k = 0; k < 3; k++) w_hz = w_hz | (w_pv[k] & (w_pa[k] == w_addr_i));
  end
  assign w_ready = ~reset_i & ((read_write_same_addr_p != 0) | w_prio | ~w_hz);
  assign w_ready_o = w_ready;
  assign req_yumi_o = w_yumi;
  assign mem_w_v_o = w_v_i & w_ready;
  assign mem_w_addr_o = w_addr_i;
  assign mem_w_data_o = w_data_i;
  assign mem_r0_v_o = w_pv[0];
  assign mem_r1_v_o = w_pv[1];
  assign mem_r2_v_o = w_pv[2];
  assign mem_r0_addr_o = w_pa[0];
  assign mem_r1_addr_o = w_pa[1];
  assign mem_r2_addr_o = w_pa[2];
  assign w_rd[0] = mem_r0_data_i;
  assign w_rd[1] = mem_r1_data_i;
  assign w_rd[2] = mem_r2_data_i;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rr <= '0;
      r_stall <= '0;
      r_pv <= '0;
    end else begin
      if (w_any) r_rr <= (w_last == id_w'(num_req_p - 1)) ? '0 : w_last + 1'b1;
      r_stall <= (read_write_same_addr_p == 0 && w_v_i && !w_ready) ? (w_prio ? r_stall : r_stall + 4'd1) : '0;
      r_pv <= w_pv;
    end
  end
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 3; k++) r_pid[k] <= w_pid[k];
  end
  // each requester holds at most one port, so at most one port drives its data
  always_comb begin
    rdata_v_o = '0;
    rdata_o = '0;
    for (int k = 0; k < 3; k++)
      if (r_pv[k]) begin
        rdata_v_o[r_pid[k]] = 1'b1;
        rdata_o[r_pid[k]] = w_rd[k];
      end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(mem_w_v_o && int'(w_addr_i) >= els_p)) else $error("write address out of range");
      for (int k = 0; k < 3; k++) begin
        assert (!(w_pv[k] && int'(w_pa[k]) >= els_p)) else $error("read address out of range");
        assert (read_write_same_addr_p != 0 || !(mem_w_v_o && w_pv[k] && w_pa[k] == w_addr_i))
          else $error("read/write address collision");
      end
    end
  end
`endif
endmodule
